// File: rtl/neuron_cfg_serializer.sv
// Serialises a parallel neuron configuration frame MSB-first under load_mode,
// then waits for the neuron's params_ready acknowledge with a bounded timeout.
module neuron_cfg_serializer #(
  parameter int unsigned FRAME_W = 24,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               params_ready,
  output logic               load_mode,
  output logic               serial_data,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [7:0]       LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_RDY
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7:0]         to_cnt;

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            // The MSB goes out in the first SHIFT cycle; shreg keeps the rest.
            shreg       <= frame_in;
            bit_cnt     <= '0;
            load_mode   <= 1'b1;
            serial_data <= frame_in[FRAME_W-1];
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            to_cnt      <= '0;
            state       <= WAIT_RDY;
          end else begin
            bit_cnt     <= bit_cnt + 1'b1;
            shreg       <= shreg << 1;
            serial_data <= shreg[FRAME_W-2];
          end
        end

        WAIT_RDY: begin
          // Acknowledge is tested first so it wins over a simultaneous timeout.
          if (params_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (to_cnt == LAST_WAIT) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          load_mode   <= 1'b0;
          serial_data <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/neuron_cfg_serializer.md
NEURON_CFG_SERIALIZER -- requirements
Module: neuron_cfg_serializer

Interface
REQ-001 Parameter FRAME_W, default 24: configuration frame length in bits (legal 2..64).
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT_RDY cycles before error (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ena  input  1  clock enable; 0 freezes all state and outputs.
REQ-006 start  input  1  request to transmit frame_in; sampled only in IDLE.
REQ-007 frame_in  input  FRAME_W  parallel parameter frame; captured on the accepting cycle.
REQ-008 params_ready  input  1  neuron acknowledges that the parameters are loaded.
REQ-009 load_mode  output  1  drives the neuron configuration-mode pin; high while bits are shifted.
REQ-010 serial_data  output  1  drives the neuron serial data pin, MSB first.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse when the frame is acknowledged.
REQ-013 error  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT and WAIT_RDY; all outputs SHALL be registered.
REQ-015 In IDLE with ena=1 and start=1, the block SHALL latch frame_in into a shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-016 In SHIFT, load_mode SHALL be 1 and serial_data SHALL present frame bit FRAME_W-1-k during the k-th SHIFT cycle (k=0..FRAME_W-1).
REQ-017 load_mode SHALL be high for exactly FRAME_W consecutive enabled cycles per frame, beginning the cycle after acceptance.
REQ-018 After bit 0, the block SHALL enter WAIT_RDY with load_mode=0 and serial_data=0, and SHALL clear the timeout counter.
REQ-019 In WAIT_RDY, params_ready sampled 1 SHALL cause done=1 for exactly one cycle and a return to IDLE on the same edge.
REQ-020 In WAIT_RDY, if params_ready stays 0 for TIMEOUT sampled cycles, the block SHALL pulse error=1 for one cycle and return to IDLE.
REQ-021 If params_ready=1 and the timeout count expire in the same cycle, done SHALL win and error SHALL stay 0.
REQ-022 params_ready SHALL be ignored in IDLE and SHIFT.
REQ-023 start SHALL be ignored while busy=1; frame_in changes after acceptance SHALL NOT affect the frame in flight.
REQ-024 busy SHALL be 1 in SHIFT and WAIT_RDY, and SHALL be 0 in the cycle done or error is pulsed.
REQ-025 A new start SHALL be accepted in the cycle immediately after done or error, giving back-to-back frames with one IDLE cycle between them.
REQ-026 With ena=0, the state, counters, shift register and all outputs SHALL hold their values, including done and error if currently high.
REQ-027 The bit counter SHALL be ceil(log2(FRAME_W)) bits and the timeout counter 8 bits; neither counter SHALL wrap within one frame.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set load_mode=0, serial_data=0, busy=0, done=0 and error=0, regardless of ena.
REQ-029 Reset during SHIFT or WAIT_RDY SHALL abort the frame without a done or error pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-030 Nominal: FRAME_W=24, frame_in=0xA5C3F0, start pulse; params_ready rises 3 cycles after load_mode falls -> serial_data sequence 1010_0101_1100_0011_1111_0000 over 24 load_mode-high cycles, then done pulse, busy=0.
REQ-031 Timeout: TIMEOUT=16, params_ready held 0 -> error pulses exactly 16 cycles after load_mode falls, done=0, back in IDLE.
REQ-032 Ignored start: start re-asserted with frame_in=0x000000 during SHIFT -> the transmitted bits remain those of the original frame; no second frame is started.
REQ-033 ena gating: ena=0 for 5 cycles mid-SHIFT at bit 10 -> load_mode and serial_data hold, and the total number of load_mode-high enabled cycles is still 24.
REQ-034 Reset mid-frame: rst_n=0 at bit 7 -> next edge all outputs 0, no done/error; a new frame 0xFFFFFF after release transmits 24 ones.
REQ-035 Collision: params_ready=1 on the final timeout cycle -> done=1 and error=0.
